// File: rtl/gcd_seg_display_pkg.sv
// Shared definitions for the GCD result display: converter states, blank pattern
// and the 7-segment decode table (segments {g,f,e,d,c,b,a}, active-low).
package gcd_seg_display_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Codes 10..15 cannot come out of the converter and are shown blank
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'd0:    pattern = 7'b1000000;
      4'd1:    pattern = 7'b1111001;
      4'd2:    pattern = 7'b0100100;
      4'd3:    pattern = 7'b0110000;
      4'd4:    pattern = 7'b0011001;
      4'd5:    pattern = 7'b0010010;
      4'd6:    pattern = 7'b0000010;
      4'd7:    pattern = 7'b1111000;
      4'd8:    pattern = 7'b0000000;
      4'd9:    pattern = 7'b0010000;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/gcd_seg_display_bin2bcd8.sv
// Sequential double-dabble converter: 8-bit binary to 3-digit BCD, one shift per clock.
// A new conversion starts whenever the input differs from the last value captured.
module bin2bcd8
  import gcd_seg_display_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic [7:0]  i_bin_in,
  output logic [11:0] o_bcd_out,
  output logic        o_busy
);

  conv_state_e r_state;
  conv_state_e w_state_next;
  logic [7:0]  r_last_val;
  logic [7:0]  r_shreg;
  logic [11:0] r_work;
  logic [2:0]  r_bitcnt;
  logic [11:0] w_adj;
  logic [11:0] w_work_shift;
  logic [7:0]  w_sh_shift;
  logic        w_start;
  logic        w_last;

  always_comb begin
    w_adj = r_work;
    for (int i = 0; i < 3; i++) begin
      if (r_work[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_work[4*i +: 4] + 4'd3;
      end
    end
    {w_work_shift, w_sh_shift} = {w_adj[10:0], r_shreg, 1'b0};
  end

  assign w_start = (r_state == ST_IDLE) && (i_bin_in != r_last_val);
  assign w_last  = (r_state == ST_CONV) && (r_bitcnt == 3'd7);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_next = ST_CONV;
      ST_CONV: if (w_last)  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // The result register is only written on the final shift, so it never shows a partial value
  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_last_val <= 8'd0;
      r_shreg    <= 8'd0;
      r_work     <= 12'd0;
      r_bitcnt   <= 3'd0;
      o_bcd_out  <= 12'h000;
      o_busy     <= 1'b0;
    end else if (w_start) begin
      r_shreg    <= i_bin_in;
      r_last_val <= i_bin_in;
      r_work     <= 12'd0;
      r_bitcnt   <= 3'd0;
      o_busy     <= 1'b1;
    end else if (r_state == ST_CONV) begin
      r_work   <= w_work_shift;
      r_shreg  <= w_sh_shift;
      r_bitcnt <= r_bitcnt + 3'd1;
      if (w_last) begin
        o_bcd_out <= w_work_shift;
        o_busy    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gcd_seg_display.sv
// Shows the GCD core result in decimal on a 3-digit multiplexed 7-segment display.
// Optional leading-zero blanking is enabled with the GCD_DISP_LZB_EN macro.
module gcd_seg_display
  import gcd_seg_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        i_clk,
  input  logic        i_clr,
  input  logic [7:0]  i_bin_in,
  output logic [6:0]  o_seg,
  output logic [3:0]  o_an,
  output logic [11:0] o_bcd_out,
  output logic        o_busy
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit_idx;
  logic [3:0]    w_nibble;
  logic [3:0]    w_an;
  logic          w_blank;
  logic [6:0]    w_seg;

  bin2bcd8 u_bin2bcd8 (
    .i_clk     (i_clk),
    .i_clr     (i_clr),
    .i_bin_in  (i_bin_in),
    .o_bcd_out (o_bcd_out),
    .o_busy    (o_busy)
  );

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      r_presc     <= '0;
      r_digit_idx <= 2'd0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc     <= '0;
      r_digit_idx <= (r_digit_idx == 2'd2) ? 2'd0 : r_digit_idx + 2'd1;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Blanked digits keep their anode active so the scan timing stays uniform
  always_comb begin
    w_nibble = 4'hF;
    w_an     = 4'b1111;
    w_blank  = 1'b0;
    case (r_digit_idx)
      2'd0: begin
        w_nibble = o_bcd_out[3:0];
        w_an     = 4'b1110;
      end
      2'd1: begin
        w_nibble = o_bcd_out[7:4];
        w_an     = 4'b1101;
`ifdef GCD_DISP_LZB_EN
        w_blank  = (o_bcd_out[11:4] == 8'h00);
`endif
      end
      2'd2: begin
        w_nibble = o_bcd_out[11:8];
        w_an     = 4'b1011;
`ifdef GCD_DISP_LZB_EN
        w_blank  = (o_bcd_out[11:8] == 4'h0);
`endif
      end
      default: begin
        w_nibble = 4'hF;
        w_an     = 4'b1111;
      end
    endcase
    w_seg = w_blank ? SEG_BLANK : seg_decode(w_nibble);
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      o_an  <= 4'b1111;
      o_seg <= SEG_BLANK;
    end else begin
      o_an  <= w_an;
      o_seg <= w_seg;
    end
  end

endmodule

// File: tb/tb_gcd_seg_display.sv
// Directed bench for gcd_seg_display with SCAN_DIV=4; expectations follow the
// GCD_DISP_LZB_EN setting of the build.
module tb_gcd_seg_display;

  localparam int SCAN_DIV = 4;

  logic        clock = 1'b0;
  logic        clr = 1'b1;
  logic [7:0]  binIn = 8'd9;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [11:0] bcdOut;
  logic        busy;

  int checks = 0;
  int failures = 0;

  gcd_seg_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .i_clk     (clock),
    .i_clr     (clr),
    .i_bin_in  (binIn),
    .o_seg     (seg),
    .o_an      (an),
    .o_bcd_out (bcdOut),
    .o_busy    (busy)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] value);
    @(negedge clock);
    binIn = value;
  endtask

  // Counts busy cycles until busy drops after having been seen high
  task automatic waitConversion(output int busyCycles);
    logic done;
    busyCycles = 0;
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clock);
      if (busy) busyCycles++;
      else if (busyCycles > 0) done = 1'b1;
    end
    if (!done) checkOutput("conv_timeout", 16'd0, 16'd1);
  endtask

  task automatic findAnode(input logic [3:0] target);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clock);
      if (an == target) found = 1'b1;
    end
    if (!found) checkOutput("scan_timeout", {12'd0, an}, {12'd0, target});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int edges;
    int orderErrors;
    int an3Low;
    logic [3:0] prevAn;
    logic [3:0] nextAn;
    logic [6:0] zeroSlot;

`ifdef GCD_DISP_LZB_EN
    zeroSlot = 7'b1111111;
`else
    zeroSlot = 7'b1000000;
`endif

    $display("[TB] reset held with bin_in=9");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("rst_seg", {9'd0, seg}, 16'h007F);
      checkOutput("rst_an", {12'd0, an}, 16'h000F);
      checkOutput("rst_bcd", {4'd0, bcdOut}, 16'h0000);
      checkOutput("rst_busy", {15'd0, busy}, 16'h0000);
    end
    clr = 1'b0;
    waitConversion(n);
    checkOutput("post_rst_bcd9", {4'd0, bcdOut}, 16'h0009);

    $display("[TB] bin_in=3");
    applyStimulus(8'd3);
    waitConversion(n);
    checkOutput("busy_len_3", n[15:0], 16'd8);
    checkOutput("bcd_3", {4'd0, bcdOut}, 16'h0003);
    findAnode(4'b1110);
    checkOutput("seg_ones_3", {9'd0, seg}, 16'h0030);

    $display("[TB] bin_in=255 then 0");
    applyStimulus(8'd255);
    waitConversion(n);
    checkOutput("bcd_255", {4'd0, bcdOut}, 16'h0255);
    findAnode(4'b1011);
    checkOutput("seg_hund_2", {9'd0, seg}, 16'h0024);
    findAnode(4'b1101);
    checkOutput("seg_tens_5", {9'd0, seg}, 16'h0012);
    findAnode(4'b1110);
    checkOutput("seg_ones_5", {9'd0, seg}, 16'h0012);
    prevAn = an;
    orderErrors = 0;
    an3Low = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (!an[3]) an3Low++;
      if (an != prevAn) begin
        case (prevAn)
          4'b1110: nextAn = 4'b1101;
          4'b1101: nextAn = 4'b1011;
          default: nextAn = 4'b1110;
        endcase
        if (an != nextAn) orderErrors++;
        prevAn = an;
      end
    end
    checkOutput("scan_order", orderErrors[15:0], 16'd0);
    checkOutput("an3_never_low", an3Low[15:0], 16'd0);
    applyStimulus(8'd0);
    waitConversion(n);
    checkOutput("bcd_0", {4'd0, bcdOut}, 16'h0000);

    $display("[TB] bin_in 24 changed to 9 during conversion");
    applyStimulus(8'd24);
    repeat (3) @(negedge clock);
    binIn = 8'd9;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clock);
      n++;
    end
    checkOutput("busy_drop_24", {15'd0, busy}, 16'h0000);
    checkOutput("bcd_24", {4'd0, bcdOut}, 16'h0024);
    @(negedge clock);
    checkOutput("busy_reassert", {15'd0, busy}, 16'h0001);
    checkOutput("bcd_24_hold", {4'd0, bcdOut}, 16'h0024);
    waitConversion(n);
    checkOutput("bcd_9", {4'd0, bcdOut}, 16'h0009);

    $display("[TB] bin_in=7 digit slots");
    applyStimulus(8'd7);
    waitConversion(n);
    checkOutput("bcd_7", {4'd0, bcdOut}, 16'h0007);
    findAnode(4'b1011);
    checkOutput("seg_hund_7", {9'd0, seg}, {9'd0, zeroSlot});
    findAnode(4'b1101);
    checkOutput("seg_tens_7", {9'd0, seg}, {9'd0, zeroSlot});
    findAnode(4'b1110);
    checkOutput("seg_ones_7", {9'd0, seg}, 16'h0078);

    $display("[TB] clr during conversion of 200");
    applyStimulus(8'd200);
    repeat (4) @(negedge clock);
    clr = 1'b1;
    #1;
    checkOutput("abort_busy", {15'd0, busy}, 16'h0000);
    checkOutput("abort_bcd", {4'd0, bcdOut}, 16'h0000);
    checkOutput("abort_an", {12'd0, an}, 16'h000F);
    checkOutput("abort_seg", {9'd0, seg}, 16'h007F);
    @(negedge clock);
    clr = 1'b0;
    edges = 0;
    for (int i = 0; i < 20 && bcdOut != 12'h200; i++) begin
      @(posedge clock);
      edges++;
      #1;
    end
    checkOutput("reconv_edges", edges[15:0], 16'd9);
    checkOutput("bcd_200", {4'd0, bcdOut}, 16'h0200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
